// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if
//   Byte-write and status bundle of the buffered UART transmitter.
//   master : the byte producer (drives data_in / tx_req, observes status)
//   slave  : the transmitter (accepts bytes, drives line and status)
// Signals:
//   data_in  [7:0] byte to transmit
//   tx_req         write strobe, accepted when tx_req && tx_ready
//   tx_ready       FIFO not full (registered)
//   tx             serial line, idle high
//   tx_busy        high for every cycle of a frame
//   tx_done        one-cycle pulse in the last stop-bit cycle
//   overflow       sticky, write attempted while not ready
interface uart_tx_buffered_if;
   logic [7:0] data_in;
   logic       tx_req;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;
   logic       overflow;

   modport master (
      output data_in, tx_req,
      input  tx_ready, tx, tx_busy, tx_done, overflow
   );

   modport slave (
      input  data_in, tx_req,
      output tx_ready, tx, tx_busy, tx_done, overflow
   );
endinterface

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered 8N1 UART transmitter. Bytes are queued in a FIFO and shifted out
//   LSB first. Back-to-back frames leave no idle gap while the FIFO holds data.
// Ports:
//   Sys_clk  system clock, all logic on its rising edge
//   Rst      synchronous active-high reset; flushes the FIFO, aborts any frame
//   bus      uart_tx_buffered_if.slave (byte write, line and status outputs)
//
// FSM states:
//   state | meaning
//   IDLE  | line high, pops the FIFO as soon as it holds a byte
//   START | start bit (line low) for BIT_CYC cycles
//   DATA  | 8 data bits, BIT_CYC cycles each, LSB first
//   STOP  | stop bit (line high); pops the next byte in its last cycle
module uart_tx_buffered #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic               Sys_clk,
   input  logic               Rst,
   uart_tx_buffered_if.slave  bus
);

   localparam int BIT_CYC = CLK_FREQ / BAUD;
   localparam int BAUD_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // FIFO
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;
   logic             r_tx_ready;
   logic             r_overflow;

   // transmit engine
   state_t           r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_tx;
   logic             r_tx_busy;
   logic             r_tx_done;

   logic             w_push;
   logic             w_pop;
   logic             w_bit_end;
   logic             w_not_empty;

   assign w_not_empty = (r_count != '0);
   assign w_bit_end   = (r_baud == BAUD_W'(BIT_CYC - 1));
   // The ready flag is registered, so a write on the edge that frees a slot
   // of a full FIFO is still refused.
   assign w_push      = bus.tx_req && r_tx_ready;
   assign w_pop       = w_not_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop)
         w_count_next = r_count + CNT_W'(1);
      else if (!w_push && w_pop)
         w_count_next = r_count - CNT_W'(1);
   end

   // Storage has no reset; only the pointers define what is valid.
   always_ff @(posedge Sys_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= bus.data_in;
   end

   always_ff @(posedge Sys_clk) begin
      if (Rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_tx_ready <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count    <= w_count_next;
         r_tx_ready <= (w_count_next < CNT_W'(FIFO_DEPTH));
         if (bus.tx_req && !r_tx_ready)
            r_overflow <= 1'b1;
      end
   end

   // Line outputs are registered from the current state, so they trail the
   // state register by one cycle; tx_done lines up with the final stop cycle
   // on the line rather than in the state register.
   always_ff @(posedge Sys_clk) begin
      if (Rst) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
         r_tx_busy <= 1'b0;
         r_tx_done <= 1'b0;
      end else begin
         r_tx_busy <= (r_state != S_IDLE);
         r_tx_done <= (r_state == S_STOP) && w_bit_end;

         unique case (r_state)
            S_IDLE:  r_tx <= 1'b1;
            S_START: r_tx <= 1'b0;
            S_DATA:  r_tx <= r_shift[0];
            S_STOP:  r_tx <= 1'b1;
            default: r_tx <= 1'b1;
         endcase

         unique case (r_state)
            S_IDLE: begin
               r_baud <= '0;
               if (w_pop) begin
                  r_shift   <= r_mem[r_rd_ptr];
                  r_bit_idx <= '0;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_state   <= S_DATA;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit_idx == 3'd7)
                     r_state <= S_STOP;
                  else
                     r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (w_pop) begin
                     r_shift   <= r_mem[r_rd_ptr];
                     r_bit_idx <= '0;
                     r_state   <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            default: begin
               r_baud  <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.tx_ready = r_tx_ready;
   assign bus.tx       = r_tx;
   assign bus.tx_busy  = r_tx_busy;
   assign bus.tx_done  = r_tx_done;
   assign bus.overflow = r_overflow;

endmodule
